// File: rtl/miriscv_mdu_pkg.sv
// Shared opcodes, FSM state type and opcode classification helpers for the RV32M MDU.
package miriscv_mdu_pkg;

   localparam int MDU_OP_WIDTH = 3;
   localparam int MDU_ITER_NUM = 32;

   localparam logic [MDU_OP_WIDTH-1:0] MDU_MUL    = 3'd0;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MULH   = 3'd1;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHSU = 3'd2;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_MULHU  = 3'd3;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_DIV    = 3'd4;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_DIVU   = 3'd5;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_REM    = 3'd6;
   localparam logic [MDU_OP_WIDTH-1:0] MDU_REMU   = 3'd7;

   typedef enum logic [1:0] {MDU_IDLE, MDU_MUL_ST, MDU_DIV_ST, MDU_DONE} mdu_state_t;

   function automatic logic is_mul(input logic [MDU_OP_WIDTH-1:0] op);
      return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_MULHU);
   endfunction

   function automatic logic is_signed_a(input logic [MDU_OP_WIDTH-1:0] op);
      return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
   endfunction

   function automatic logic is_signed_b(input logic [MDU_OP_WIDTH-1:0] op);
      return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
   endfunction

endpackage

// File: rtl/miriscv_mdu_abs.sv
// Operand magnitude: strips the sign of a two's-complement value when it is treated as signed.
module miriscv_mdu_abs #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] value,
   input  logic            is_signed,
   output logic [XLEN-1:0] magnitude,
   output logic            sign
);

   assign sign      = is_signed & value[XLEN-1];
   assign magnitude = sign ? -value : value;

endmodule

// File: rtl/miriscv_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider, one bit per cycle.
// Define MIRISCV_MDU_FAST_MUL_EN to replace the iterative multiplier with a single-cycle multiply.
module miriscv_mdu
   import miriscv_mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                    clk_i,
   input  logic                    arstn_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [MDU_OP_WIDTH-1:0] req_op_i,
   input  logic [XLEN-1:0]         req_a_i,
   input  logic [XLEN-1:0]         req_b_i,
   input  logic                    kill_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [XLEN-1:0]         rsp_result_o
);

   mdu_state_t              state_q;
   logic [4:0]              cnt_q;
   logic [MDU_OP_WIDTH-1:0] op_q;
   logic                    neg_res_q, sign_a_q;
   logic [XLEN-1:0]         opa_q, opb_q, quo_q, rem_q, result_q;
   logic [2*XLEN-1:0]       acc_q;
   logic                    ready_q, valid_q;

   logic [XLEN-1:0]         mag_a, mag_b;
   logic                    sign_a, sign_b;

   miriscv_mdu_abs #(.XLEN(XLEN)) u_abs_a (
      .value(req_a_i), .is_signed(is_signed_a(req_op_i)), .magnitude(mag_a), .sign(sign_a)
   );
   miriscv_mdu_abs #(.XLEN(XLEN)) u_abs_b (
      .value(req_b_i), .is_signed(is_signed_b(req_op_i)), .magnitude(mag_b), .sign(sign_b)
   );

   // Divide corner cases resolve at accept time and skip the iteration entirely.
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] early_res;

   assign div_zero = (req_b_i == '0);
   assign div_ovf  = is_signed_b(req_op_i) && !is_mul(req_op_i) &&
                     (req_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (req_b_i == '1);

   always_comb begin
      early_res = '0;
      if (div_zero)
         early_res = req_op_i[1] ? req_a_i : '1;
      else if (!req_op_i[1])
         early_res = {1'b1, {(XLEN-1){1'b0}}};
   end

`ifdef MIRISCV_MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   logic [XLEN-1:0]   fast_res;
   logic              ext_a, ext_b;

   // Low 64 bits of the sign-extended product equal the 33x33 signed product.
   assign ext_a     = is_signed_a(req_op_i) & req_a_i[XLEN-1];
   assign ext_b     = is_signed_b(req_op_i) & req_b_i[XLEN-1];
   assign fast_prod = {{XLEN{ext_a}}, req_a_i} * {{XLEN{ext_b}}, req_b_i};
   assign fast_res  = (req_op_i == MDU_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

   // Shift-add step: opa_q is the multiplicand, opb_q the shifting multiplier.
   logic [2*XLEN-1:0] mcand_sh, acc_nxt, prod;
   logic [XLEN-1:0]   mul_res;

   assign mcand_sh = {{XLEN{1'b0}}, opa_q} << cnt_q;
   assign acc_nxt  = opb_q[0] ? acc_q + mcand_sh : acc_q;
   assign prod     = neg_res_q ? -acc_nxt : acc_nxt;
   assign mul_res  = (op_q == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

   // Restoring step: opa_q is the dividend, opb_q the divisor; the partial remainder needs 33 bits.
   logic [XLEN:0]   rem_sh;
   logic            rem_ge;
   logic [XLEN-1:0] rem_nxt, quo_nxt, div_res;

   assign rem_sh  = {rem_q, opa_q[5'(XLEN-1) - cnt_q]};
   assign rem_ge  = rem_sh >= {1'b0, opb_q};
   assign rem_nxt = rem_ge ? rem_sh[XLEN-1:0] - opb_q : rem_sh[XLEN-1:0];

   always_comb begin
      quo_nxt = quo_q;
      quo_nxt[5'(XLEN-1) - cnt_q] = rem_ge;
   end

   assign div_res = op_q[1] ? (sign_a_q ? -rem_nxt : rem_nxt)
                            : (neg_res_q ? -quo_nxt : quo_nxt);

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q   <= MDU_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         neg_res_q <= 1'b0;
         sign_a_q  <= 1'b0;
         opa_q     <= '0;
         opb_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         acc_q     <= '0;
         result_q  <= '0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
      end else if (kill_i) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            MDU_IDLE: if (req_valid_i) begin
               op_q      <= req_op_i;
               neg_res_q <= sign_a ^ sign_b;
               sign_a_q  <= sign_a;
               opa_q     <= mag_a;
               opb_q     <= mag_b;
               acc_q     <= '0;
               quo_q     <= '0;
               rem_q     <= '0;
               cnt_q     <= '0;
               ready_q   <= 1'b0;
               if (is_mul(req_op_i)) begin
`ifdef MIRISCV_MDU_FAST_MUL_EN
                  result_q <= fast_res;
                  valid_q  <= 1'b1;
                  state_q  <= MDU_DONE;
`else
                  state_q  <= MDU_MUL_ST;
`endif
               end else if (div_zero || div_ovf) begin
                  result_q <= early_res;
                  valid_q  <= 1'b1;
                  state_q  <= MDU_DONE;
               end else begin
                  state_q  <= MDU_DIV_ST;
               end
            end
            MDU_MUL_ST: begin
               acc_q <= acc_nxt;
               opb_q <= opb_q >> 1;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'(MDU_ITER_NUM-1)) begin
                  result_q <= mul_res;
                  valid_q  <= 1'b1;
                  state_q  <= MDU_DONE;
               end
            end
            MDU_DIV_ST: begin
               rem_q <= rem_nxt;
               quo_q <= quo_nxt;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'(MDU_ITER_NUM-1)) begin
                  result_q <= div_res;
                  valid_q  <= 1'b1;
                  state_q  <= MDU_DONE;
               end
            end
            MDU_DONE: if (rsp_ready_i) begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= MDU_IDLE;
            end
            default: state_q <= MDU_IDLE;
         endcase
      end
   end

   assign req_ready_o  = ready_q;
   assign rsp_valid_o  = valid_q;
   assign rsp_result_o = result_q;

endmodule
